// File: rtl/rc_pkg.sv
// Shared types and constants for the RC link supervisor slice: channel type,
// supervisor state encoding and a channel legality helper.
package rc_pkg;

    localparam int CH_W       = 12;
    localparam int CENTER_DEF = 512;

    typedef logic [CH_W-1:0] rc_ch_t;

    typedef enum logic [1:0] {
        NO_LINK  = 2'd0,
        DISARMED = 2'd1,
        ARMED    = 2'd2,
        FAILSAFE = 2'd3
    } rc_state_t;

    function automatic logic ch_legal(input rc_ch_t ch, input rc_ch_t ch_max);
        return ch <= ch_max;
    endfunction

endpackage

// File: rtl/rc_link_supervisor_if.sv
// Bundle between the PPM decoder side (master) and the link supervisor
// (slave), including the supervisor's state for observation.
interface rc_link_supervisor_if;
    import rc_pkg::*;

    // frame_strobe is a valid-only qualifier: the ch_* fields are taken on the
    // clock edge where it is 1, and the supervisor never applies back-pressure.
    logic      frame_strobe;
    rc_ch_t    ch_throttle;
    rc_ch_t    ch_roll;
    rc_ch_t    ch_pitch;
    rc_ch_t    ch_yaw;
    rc_ch_t    ch_arm;

    rc_ch_t    throttle_out;
    rc_ch_t    roll_out;
    rc_ch_t    pitch_out;
    rc_ch_t    yaw_out;
    logic      armed;
    logic      failsafe;
    logic      link_ok;
    rc_state_t state_dbg;

    modport master (
        output frame_strobe, ch_throttle, ch_roll, ch_pitch, ch_yaw, ch_arm,
        input  throttle_out, roll_out, pitch_out, yaw_out,
        input  armed, failsafe, link_ok, state_dbg
    );

    modport slave (
        input  frame_strobe, ch_throttle, ch_roll, ch_pitch, ch_yaw, ch_arm,
        output throttle_out, roll_out, pitch_out, yaw_out,
        output armed, failsafe, link_ok, state_dbg
    );

endinterface

// File: rtl/rc_link_watchdog.sv
// Frame validation, link-loss watchdog and consecutive-good-frame run counter.
// timeout and link_acquired are single-cycle events for the supervisor FSM.
module rc_link_watchdog
    import rc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter int unsigned GOOD_FRAMES    = 3,
    parameter int unsigned CH_MAX         = 1023
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   frame_strobe,
    input  rc_ch_t ch_throttle,
    input  rc_ch_t ch_roll,
    input  rc_ch_t ch_pitch,
    input  rc_ch_t ch_yaw,
    input  rc_ch_t ch_arm,
    output logic   good_frame,
    output logic   timeout,
    output logic   link_acquired
);

    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RUN_W = $clog2(GOOD_FRAMES + 1);

    localparam rc_ch_t           CH_LIM  = rc_ch_t'(CH_MAX);
    localparam logic [WD_W-1:0]  WD_SAT  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(GOOD_FRAMES);
    localparam logic [RUN_W-1:0] RUN_ACQ = RUN_W'(GOOD_FRAMES - 1);

    logic [WD_W-1:0]  wd_q;
    logic [RUN_W-1:0] run_q;
    logic             frame_legal;

    assign frame_legal = ch_legal(ch_throttle, CH_LIM) && ch_legal(ch_roll, CH_LIM) &&
                         ch_legal(ch_pitch, CH_LIM) && ch_legal(ch_yaw, CH_LIM) &&
                         ch_legal(ch_arm, CH_LIM);

    assign good_frame = frame_strobe && frame_legal;

    // Fires only on the step into saturation, so a dead link raises it once;
    // a good frame on that same cycle suppresses it.
    assign timeout = !good_frame && (wd_q == WD_LAST);

    assign link_acquired = good_frame && (run_q >= RUN_ACQ);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_q  <= '0;
            run_q <= '0;
        end else begin
            if (good_frame) begin
                wd_q <= '0;
            end else if (wd_q != WD_SAT) begin
                wd_q <= wd_q + WD_W'(1);
            end

            if (good_frame) begin
                if (run_q != RUN_SAT) begin
                    run_q <= run_q + RUN_W'(1);
                end
            end else if (frame_strobe || timeout) begin
                run_q <= '0;
            end
        end
    end

endmodule

// File: rtl/rc_link_supervisor.sv
// RC link supervisor: frame validation, link watchdog, arm/disarm FSM and
// failsafe throttle descent. Optional stick deadband under RC_DEADBAND_EN.
module rc_link_supervisor
    import rc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter int unsigned GOOD_FRAMES    = 3,
    parameter int unsigned ARM_THRESH     = 500,
    parameter int unsigned THR_ARM_MAX    = 50,
    parameter int unsigned CH_MAX         = 1023,
    parameter int unsigned CENTER         = CENTER_DEF,
    parameter int unsigned RAMP_PERIOD    = 500_000,
    parameter int unsigned RAMP_STEP      = 4
`ifdef RC_DEADBAND_EN
    ,
    parameter int unsigned DEADBAND       = 8
`endif
) (
    input logic clk,
    input logic rst,
    rc_link_supervisor_if.slave bus
);

    localparam int RAMP_W = $clog2(RAMP_PERIOD + 1);

    localparam rc_ch_t            CENTER_V  = rc_ch_t'(CENTER);
    localparam rc_ch_t            ARM_TH_V  = rc_ch_t'(ARM_THRESH);
    localparam rc_ch_t            THR_MAX_V = rc_ch_t'(THR_ARM_MAX);
    localparam rc_ch_t            STEP_V    = rc_ch_t'(RAMP_STEP);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_PERIOD - 1);

`ifdef RC_DEADBAND_EN
    localparam logic signed [CH_W:0] DB_V = (CH_W + 1)'(DEADBAND);

    function automatic rc_ch_t stick(input rc_ch_t ch);
        logic signed [CH_W:0] diff;
        diff = $signed({1'b0, ch}) - $signed({1'b0, CENTER_V});
        if ((diff <= DB_V) && (diff >= -DB_V)) begin
            return CENTER_V;
        end
        return ch;
    endfunction
`else
    function automatic rc_ch_t stick(input rc_ch_t ch);
        return ch;
    endfunction
`endif

    logic good_frame;
    logic timeout;
    logic link_acquired;

    rc_link_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .GOOD_FRAMES    (GOOD_FRAMES),
        .CH_MAX         (CH_MAX)
    ) u_watchdog (
        .clk           (clk),
        .rst           (rst),
        .frame_strobe  (bus.frame_strobe),
        .ch_throttle   (bus.ch_throttle),
        .ch_roll       (bus.ch_roll),
        .ch_pitch      (bus.ch_pitch),
        .ch_yaw        (bus.ch_yaw),
        .ch_arm        (bus.ch_arm),
        .good_frame    (good_frame),
        .timeout       (timeout),
        .link_acquired (link_acquired)
    );

    rc_state_t         state_q, state_d;
    rc_ch_t            thr_q, thr_d;
    rc_ch_t            roll_q, roll_d;
    rc_ch_t            pitch_q, pitch_d;
    rc_ch_t            yaw_q, yaw_d;
    logic              prev_arm_q, prev_arm_d;
    logic [RAMP_W-1:0] ramp_q, ramp_d;

    logic   arm_hi;
    logic   arm_lo;
    logic   arm_level;
    logic   arm_rise;
    rc_ch_t thr_ramped;
    rc_ch_t roll_in;
    rc_ch_t pitch_in;
    rc_ch_t yaw_in;

    // A frame exactly at the threshold keeps whatever level was seen last.
    assign arm_hi     = bus.ch_arm > ARM_TH_V;
    assign arm_lo     = bus.ch_arm < ARM_TH_V;
    assign arm_level  = arm_hi || (!arm_lo && prev_arm_q);
    assign arm_rise   = !prev_arm_q && arm_level;
    assign thr_ramped = (thr_q > STEP_V) ? (thr_q - STEP_V) : '0;

    assign roll_in  = stick(bus.ch_roll);
    assign pitch_in = stick(bus.ch_pitch);
    assign yaw_in   = stick(bus.ch_yaw);

    always_comb begin
        state_d    = state_q;
        thr_d      = thr_q;
        roll_d     = roll_q;
        pitch_d    = pitch_q;
        yaw_d      = yaw_q;
        prev_arm_d = prev_arm_q;
        ramp_d     = ramp_q;

        if (good_frame) begin
            prev_arm_d = arm_level;
        end

        case (state_q)
            NO_LINK: begin
                if (link_acquired) begin
                    state_d = DISARMED;
                    roll_d  = roll_in;
                    pitch_d = pitch_in;
                    yaw_d   = yaw_in;
                end
            end

            DISARMED: begin
                if (timeout) begin
                    state_d = NO_LINK;
                    roll_d  = CENTER_V;
                    pitch_d = CENTER_V;
                    yaw_d   = CENTER_V;
                end else if (good_frame) begin
                    roll_d  = roll_in;
                    pitch_d = pitch_in;
                    yaw_d   = yaw_in;
                    if (arm_rise && (bus.ch_throttle < THR_MAX_V)) begin
                        state_d = ARMED;
                        thr_d   = bus.ch_throttle;
                    end
                end
            end

            ARMED: begin
                if (timeout) begin
                    // Throttle is held at its last commanded value as the ramp start.
                    state_d = FAILSAFE;
                    ramp_d  = '0;
                    roll_d  = CENTER_V;
                    pitch_d = CENTER_V;
                    yaw_d   = CENTER_V;
                end else if (good_frame) begin
                    roll_d  = roll_in;
                    pitch_d = pitch_in;
                    yaw_d   = yaw_in;
                    if (!arm_level) begin
                        state_d = DISARMED;
                        thr_d   = '0;
                    end else begin
                        thr_d   = bus.ch_throttle;
                    end
                end
            end

            FAILSAFE: begin
                if (link_acquired) begin
                    ramp_d  = '0;
                    roll_d  = roll_in;
                    pitch_d = pitch_in;
                    yaw_d   = yaw_in;
                    if (arm_hi) begin
                        state_d = ARMED;
                        thr_d   = bus.ch_throttle;
                    end else begin
                        state_d = DISARMED;
                        thr_d   = '0;
                    end
                end else if (ramp_q == RAMP_LAST) begin
                    ramp_d = '0;
                    thr_d  = thr_ramped;
                    if (thr_ramped == '0) begin
                        state_d = NO_LINK;
                    end
                end else begin
                    ramp_d = ramp_q + RAMP_W'(1);
                end
            end

            default: begin
                state_d = NO_LINK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= NO_LINK;
            thr_q      <= '0;
            roll_q     <= CENTER_V;
            pitch_q    <= CENTER_V;
            yaw_q      <= CENTER_V;
            prev_arm_q <= 1'b1;
            ramp_q     <= '0;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            roll_q     <= roll_d;
            pitch_q    <= pitch_d;
            yaw_q      <= yaw_d;
            prev_arm_q <= prev_arm_d;
            ramp_q     <= ramp_d;
        end
    end

    assign bus.throttle_out = thr_q;
    assign bus.roll_out     = roll_q;
    assign bus.pitch_out    = pitch_q;
    assign bus.yaw_out      = yaw_q;
    assign bus.armed        = (state_q == ARMED) || (state_q == FAILSAFE);
    assign bus.failsafe     = (state_q == FAILSAFE);
    assign bus.link_ok      = (state_q == DISARMED) || (state_q == ARMED);
    assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_rc_link_supervisor.sv
// Bench for rc_link_supervisor: directed scenarios plus random frames, checked
// every cycle against a behavioural model of the link/arm/failsafe rules.
module tb_rc_link_supervisor;
    import rc_pkg::*;

    localparam int TO    = 1000;
    localparam int RP    = 100;
    localparam int GF    = 3;
    localparam int ATH   = 500;
    localparam int TAM   = 50;
    localparam int CMAX  = 1023;
    localparam int CTR   = 512;
    localparam int STEP  = 4;
    localparam int DB    = 8;
    localparam int OUT_W = 2 + 3 + 4 * CH_W;

    localparam int M_NOLINK = 0;
    localparam int M_DIS    = 1;
    localparam int M_ARM    = 2;
    localparam int M_FS     = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rc_link_supervisor_if bus();

    rc_link_supervisor #(
        .TIMEOUT_CYCLES (TO),
        .RAMP_PERIOD    (RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] dut_vec;

    assign dut_vec = {bus.state_dbg, bus.link_ok, bus.failsafe, bus.armed,
                      bus.throttle_out, bus.roll_out, bus.pitch_out, bus.yaw_out};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode, m_silence, m_run, m_fs_age, m_fs_thr0;
    int m_thr, m_roll, m_pitch, m_yaw;
    bit m_prev_hi;

    function automatic int exp_stick(input int ch);
`ifdef RC_DEADBAND_EN
        if ((ch - CTR <= DB) && (CTR - ch <= DB)) return CTR;
`endif
        return ch;
    endfunction

    function automatic logic [OUT_W-1:0] model_vec();
        rc_state_t s;
        logic lnk, fs, arm;
        case (m_mode)
            M_NOLINK: s = NO_LINK;
            M_DIS:    s = DISARMED;
            M_ARM:    s = ARMED;
            default:  s = FAILSAFE;
        endcase
        lnk = (m_mode == M_DIS) || (m_mode == M_ARM);
        fs  = (m_mode == M_FS);
        arm = (m_mode == M_ARM) || (m_mode == M_FS);
        return {s, lnk, fs, arm, CH_W'(m_thr), CH_W'(m_roll), CH_W'(m_pitch), CH_W'(m_yaw)};
    endfunction

    always @(posedge clk) begin : model_step
        int thr, roll, pitch, yaw, arm;
        bit strobe, good, bad, to, acq, lvl;
        strobe = bus.frame_strobe;
        thr    = int'(bus.ch_throttle);
        roll   = int'(bus.ch_roll);
        pitch  = int'(bus.ch_pitch);
        yaw    = int'(bus.ch_yaw);
        arm    = int'(bus.ch_arm);
        if (!rst) begin
            m_mode = M_NOLINK; m_silence = 0; m_run = 0; m_prev_hi = 1'b1;
            m_fs_age = 0; m_fs_thr0 = 0;
            m_thr = 0; m_roll = CTR; m_pitch = CTR; m_yaw = CTR;
        end else begin
            good = strobe && thr <= CMAX && roll <= CMAX && pitch <= CMAX && yaw <= CMAX && arm <= CMAX;
            bad  = strobe && !good;
            to   = 1'b0;
            if (good) m_silence = 0;
            else if (m_silence < TO) begin
                m_silence++;
                to = (m_silence == TO);
            end
            if (good) m_run = (m_run < GF) ? m_run + 1 : GF;
            else if (bad || to) m_run = 0;
            acq = good && (m_run == GF);
            lvl = (arm > ATH) ? 1'b1 : (arm < ATH) ? 1'b0 : m_prev_hi;
            case (m_mode)
                M_NOLINK: if (acq) begin
                    m_mode = M_DIS;
                    m_roll = exp_stick(roll); m_pitch = exp_stick(pitch); m_yaw = exp_stick(yaw);
                end
                M_DIS: if (to) begin
                    m_mode = M_NOLINK; m_roll = CTR; m_pitch = CTR; m_yaw = CTR;
                end else if (good) begin
                    m_roll = exp_stick(roll); m_pitch = exp_stick(pitch); m_yaw = exp_stick(yaw);
                    if (!m_prev_hi && lvl && thr < TAM) begin
                        m_mode = M_ARM; m_thr = thr;
                    end
                end
                M_ARM: if (to) begin
                    m_mode = M_FS; m_fs_age = 0; m_fs_thr0 = m_thr;
                    m_roll = CTR; m_pitch = CTR; m_yaw = CTR;
                end else if (good) begin
                    m_roll = exp_stick(roll); m_pitch = exp_stick(pitch); m_yaw = exp_stick(yaw);
                    if (!lvl) begin m_mode = M_DIS; m_thr = 0; end
                    else m_thr = thr;
                end
                default: if (acq) begin
                    m_roll = exp_stick(roll); m_pitch = exp_stick(pitch); m_yaw = exp_stick(yaw);
                    if (arm > ATH) begin m_mode = M_ARM; m_thr = thr; end
                    else begin m_mode = M_DIS; m_thr = 0; end
                end else begin
                    m_fs_age++;
                    m_thr = m_fs_thr0 - STEP * (m_fs_age / RP);
                    if (m_thr < 0) m_thr = 0;
                    if ((m_fs_age % RP == 0) && (m_thr == 0)) m_mode = M_NOLINK;
                end
            endcase
            if (good) m_prev_hi = lvl;
        end
        exp_q.push_back(model_vec());
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [OUT_W-1:0] e;
            e = exp_q.pop_front();
            chk("cycle", 64'(dut_vec), 64'(e));
        end
    end

    // ---------------- driver tasks ----------------
    function automatic int rs();
        return int'($urandom_range(0, 1023));
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int thr, input int roll, input int pitch, input int yaw, input int arm);
        bus.ch_throttle  = CH_W'(thr);
        bus.ch_roll      = CH_W'(roll);
        bus.ch_pitch     = CH_W'(pitch);
        bus.ch_yaw       = CH_W'(yaw);
        bus.ch_arm       = CH_W'(arm);
        bus.frame_strobe = 1'b1;
        @(negedge clk);
        bus.frame_strobe = 1'b0;
    endtask

    task automatic frame_rs(input int thr, input int arm);
        drive(thr, rs(), rs(), rs(), arm);
    endtask

    task automatic acquire(input int arm);
        frame_rs(0, arm); idle(49);
        frame_rs(0, arm); idle(49);
        frame_rs(0, arm);
    endtask

    task automatic arm_up(input int thr);
        frame_rs(0, 100); idle(20);
        frame_rs(thr, 900);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.frame_strobe = 1'b0;
        bus.ch_throttle = '0; bus.ch_roll = '0; bus.ch_pitch = '0; bus.ch_yaw = '0; bus.ch_arm = '0;
        rst = 1'b0;
        idle(3);
        chk("rst_state", bus.state_dbg, NO_LINK);
        chk("rst_thr", bus.throttle_out, 0);
        chk("rst_roll", bus.roll_out, CTR);
        chk("rst_link", bus.link_ok, 0);
        rst = 1'b1;

        // Acquire link: three good frames 500 cycles apart.
        frame_rs(0, 100); idle(499);
        frame_rs(0, 100); idle(499);
        chk("pre_acq_link", bus.link_ok, 0);
        drive(0, 700, 300, 90, 100);
        chk("acq_link", bus.link_ok, 1);
        chk("acq_armed", bus.armed, 0);
        chk("acq_roll", bus.roll_out, 700);

        // Arm with low throttle, disarm, refuse arming with high throttle.
        idle(20); arm_up(20);
        chk("arm_ok", bus.armed, 1);
        idle(20); frame_rs(20, 100);
        chk("disarm", bus.armed, 0);
        chk("disarm_thr", bus.throttle_out, 0);
        idle(20); frame_rs(60, 900);
        chk("arm_thr_hi", bus.armed, 0);

        // Failsafe descent from 400 all the way to NO_LINK.
        idle(20); arm_up(20);
        idle(20); frame_rs(400, 900);
        chk("armed_thr", bus.throttle_out, 400);
        idle(999);
        chk("pre_timeout", bus.failsafe, 0);
        idle(1);
        chk("timeout_fs", bus.failsafe, 1);
        chk("timeout_link", bus.link_ok, 0);
        idle(100);
        chk("ramp_1", bus.throttle_out, 396);
        idle(9899);
        chk("ramp_last", bus.throttle_out, 4);
        idle(1);
        chk("ramp_end_state", bus.state_dbg, NO_LINK);
        chk("ramp_end_armed", bus.armed, 0);

        // Recover from failsafe with arm high, then with arm low.
        acquire(100); idle(20); arm_up(20);
        idle(20); frame_rs(300, 900);
        idle(1000);
        chk("fs2", bus.failsafe, 1);
        idle(250);
        chk("fs2_ramp", bus.throttle_out, 292);
        frame_rs(100, 900); idle(29);
        frame_rs(120, 900); idle(29);
        frame_rs(150, 900);
        chk("fs_rearm_state", bus.state_dbg, ARMED);
        chk("fs_rearm_thr", bus.throttle_out, 150);
        idle(1000);
        chk("fs3", bus.failsafe, 1);
        acquire(100);
        chk("fs_disarm_state", bus.state_dbg, DISARMED);
        chk("fs_disarm_thr", bus.throttle_out, 0);

        // Bad frame breaks the good-frame run.
        idle(1000);
        chk("lost_state", bus.state_dbg, NO_LINK);
        frame_rs(0, 100); idle(10);
        frame_rs(0, 100); idle(10);
        drive(0, 2000, 512, 512, 100); idle(10);
        frame_rs(0, 100);
        chk("bad_run_reset", bus.state_dbg, NO_LINK);
        idle(10); frame_rs(0, 100); idle(10); frame_rs(0, 100);
        chk("bad_reacq", bus.state_dbg, DISARMED);

        // Good frame exactly on the timeout cycle.
        idle(20); arm_up(20);
        idle(20); frame_rs(120, 900);
        idle(999); frame_rs(120, 900);
        chk("edge_frame_state", bus.state_dbg, ARMED);
        idle(999); frame_rs(110, 900);
        chk("edge_frame_fs", bus.failsafe, 0);

        // Reset in the middle of a failsafe descent.
        idle(1000);
        chk("fs4", bus.failsafe, 1);
        idle(250);
        rst = 1'b0; idle(1); rst = 1'b1;
        chk("mid_rst_state", bus.state_dbg, NO_LINK);
        chk("mid_rst_thr", bus.throttle_out, 0);
        chk("mid_rst_pitch", bus.pitch_out, CTR);
        chk("mid_rst_armed", bus.armed, 0);
        chk("mid_rst_fs", bus.failsafe, 0);

        // Sticks around center.
        acquire(100); idle(5);
        drive(0, 518, 512, 600, 100);
        chk("stick_518", bus.roll_out, exp_stick(518));
        idle(5); drive(0, 521, 505, 503, 100);
        chk("stick_521", bus.roll_out, exp_stick(521));
        chk("stick_pitch_505", bus.pitch_out, exp_stick(505));
        chk("stick_yaw_503", bus.yaw_out, exp_stick(503));

        // Random frames, arm levels, bad frames and silences.
        for (int i = 0; i < 80; i++) begin
            int kind, sel, thr, arm_v;
            int v[5];
            kind = int'($urandom_range(0, 9));
            sel  = int'($urandom_range(0, 3));
            arm_v = (sel == 0) ? 100 : (sel == 1) ? 500 : (sel == 2) ? 900 : rs();
            thr  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 49)) : int'($urandom_range(0, 200));
            for (int k = 1; k < 4; k++) begin
                v[k] = ($urandom_range(0, 1) == 0) ? CTR - 12 + int'($urandom_range(0, 24)) : rs();
            end
            v[0] = thr;
            v[4] = arm_v;
            if (kind == 0) begin
                idle(TO + int'($urandom_range(0, 50)));
            end else if (kind == 1) begin
                v[int'($urandom_range(0, 4))] = 1024 + int'($urandom_range(0, 3071));
                drive(v[0], v[1], v[2], v[3], v[4]);
            end else begin
                drive(v[0], v[1], v[2], v[3], v[4]);
            end
            idle(int'($urandom_range(0, 300)));
        end

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
